// File: rtl/led_pattern_gen.sv
// Multi-channel LED blink-pattern generator: shared 1/16 s prescaler, global 4-bit phase, per-channel mode.
// Optional macro LED_PAT_SYNC_EN adds a 2-flop synchronizer on MODE_I and LAMP_TEST_I.
module led_pattern_gen #(
   parameter int CLK_FRQ    = 25000000,
   parameter int NUM_CH     = 4,
   parameter int BURST_SEC  = 4,
   parameter int CUST_TICKS = 11
) (
   input  logic                  SYSCLK,
   input  logic                  RESET_N,
   input  logic [3*NUM_CH-1:0]   MODE_I,
   input  logic                  LAMP_TEST_I,
   output logic [NUM_CH-1:0]     LED_O,
   output logic                  TICK_O,
   output logic [3:0]            PHASE_O
);

   localparam int TICK_DIV = CLK_FRQ / 16;
   localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [3:0]       BS_LAST  = 4'(BURST_SEC - 1);
   localparam logic [7:0]       CC_LAST  = 8'(CUST_TICKS - 1);

   localparam logic [2:0] MODE_OFF    = 3'd0;
   localparam logic [2:0] MODE_ON     = 3'd1;
   localparam logic [2:0] MODE_1HZ    = 3'd2;
   localparam logic [2:0] MODE_2HZ    = 3'd3;
   localparam logic [2:0] MODE_4HZ    = 3'd4;
   localparam logic [2:0] MODE_BURST  = 3'd5;
   localparam logic [2:0] MODE_CUSTOM = 3'd6;

   logic [3*NUM_CH-1:0] mode_in;
   logic                lamp_in;

`ifdef LED_PAT_SYNC_EN
   logic [3*NUM_CH-1:0] mode_s1_q, mode_s2_q;
   logic                lamp_s1_q, lamp_s2_q;

   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         mode_s1_q <= '0;
         mode_s2_q <= '0;
         lamp_s1_q <= 1'b0;
         lamp_s2_q <= 1'b0;
      end else begin
         mode_s1_q <= MODE_I;
         mode_s2_q <= mode_s1_q;
         lamp_s1_q <= LAMP_TEST_I;
         lamp_s2_q <= lamp_s1_q;
      end
   end

   assign mode_in = mode_s2_q;
   assign lamp_in = lamp_s2_q;
`else
   assign mode_in = MODE_I;
   assign lamp_in = LAMP_TEST_I;
`endif

   logic [PRE_W-1:0] pre_q, pre_d;
   logic             tick_q;
   logic [3:0]       ph_q, ph_d;
   logic             tick_now;

   // The tick condition is decoded from the prescaler so PH and the local counters step on the same edge TICK_O rises.
   assign tick_now = (pre_q == PRE_LAST);

   always_comb begin
      pre_d = tick_now ? '0 : pre_q + 1'b1;
      ph_d  = tick_now ? ph_q + 4'd1 : ph_q;
   end

   logic [NUM_CH-1:0][2:0] mode_q, mode_d;
   logic [NUM_CH-1:0][3:0] bs_q, bs_d;
   logic [NUM_CH-1:0][7:0] cc_q, cc_d;
   logic [NUM_CH-1:0]      ct_q, ct_d;
   logic [NUM_CH-1:0]      led_q, led_d;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      mode_d = mode_q;
      bs_d   = bs_q;
      cc_d   = cc_q;
      ct_d   = ct_q;
      led_d  = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         if (mode_in[3*n +: 3] != mode_q[n]) begin
            // A mode change wins over a coincident tick and blanks the LED for one cycle.
            mode_d[n] = mode_in[3*n +: 3];
            bs_d[n]   = '0;
            cc_d[n]   = '0;
            ct_d[n]   = 1'b0;
         end else begin
            if (tick_now && mode_q[n] == MODE_BURST && ph_q == 4'd15) begin
               bs_d[n] = (bs_q[n] == BS_LAST) ? 4'd0 : bs_q[n] + 4'd1;
            end
            if (tick_now && mode_q[n] == MODE_CUSTOM) begin
               if (cc_q[n] == CC_LAST) begin
                  cc_d[n] = '0;
                  ct_d[n] = ~ct_q[n];
               end else begin
                  cc_d[n] = cc_q[n] + 8'd1;
               end
            end
            case (mode_q[n])
               MODE_OFF:    led_d[n] = 1'b0;
               MODE_ON:     led_d[n] = 1'b1;
               MODE_1HZ:    led_d[n] = (ph_q < 4'd8);
               MODE_2HZ:    led_d[n] = ~ph_q[2];
               MODE_4HZ:    led_d[n] = ~ph_q[1];
               MODE_BURST:  led_d[n] = (bs_q[n] == 4'd0) && (ph_q < 4'd8) && ~ph_q[1];
               MODE_CUSTOM: led_d[n] = ct_q[n];
               default:     led_d[n] = 1'b0;
            endcase
         end
      end
      // Lamp test only overrides the drive; counters keep running so patterns resume in phase.
      if (lamp_in) led_d = '1;
   end

   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         // NOTE: the per-channel state is a handful of flops, not a RAM, so it is reset with everything else.
         pre_q  <= '0;
         tick_q <= 1'b0;
         ph_q   <= '0;
         mode_q <= '0;
         bs_q   <= '0;
         cc_q   <= '0;
         ct_q   <= '0;
         led_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         pre_q  <= pre_d;
         tick_q <= tick_now;
         ph_q   <= ph_d;
         mode_q <= mode_d;
         bs_q   <= bs_d;
         cc_q   <= cc_d;
         ct_q   <= ct_d;
         led_q  <= led_d;
      end
   end

   assign LED_O   = led_q;
   assign TICK_O  = tick_q;
   assign PHASE_O = ph_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen at CLK_FRQ=160 (TICK_DIV=10); k counts rising edges since reset release.
module tb_led_pattern_gen;

   logic        SYSCLK = 1'b0;
   logic        RESET_N;
   logic [11:0] MODE_I;
   logic        LAMP_TEST_I;
   logic [3:0]  LED_O;
   logic        TICK_O;
   logic [3:0]  PHASE_O;

   int errors = 0;
   int checks = 0;
   int k;

   always #5 SYSCLK = ~SYSCLK;

   led_pattern_gen #(
      .CLK_FRQ    (160),
      .NUM_CH     (4),
      .BURST_SEC  (4),
      .CUST_TICKS (11)
   ) dut (
      .SYSCLK      (SYSCLK),
      .RESET_N     (RESET_N),
      .MODE_I      (MODE_I),
      .LAMP_TEST_I (LAMP_TEST_I),
      .LED_O       (LED_O),
      .TICK_O      (TICK_O),
      .PHASE_O     (PHASE_O)
   );

   task automatic step();
      @(posedge SYSCLK);
      #1;
   endtask

   // ch0 = 1 Hz (80 hi / 80 lo), ch1 = 4 Hz (20/20), ch2 = burst (hi at 0..19 and 40..59 of each 640).
   function automatic logic [2:0] exp_low3(input int kk);
      int j;
      j = kk - 1;
      exp_low3[0] = (j % 160) < 80;
      exp_low3[1] = (j % 40) < 20;
      exp_low3[2] = ((j % 640) < 20) || (((j % 640) >= 40) && ((j % 640) < 60));
   endfunction

   // ch3 toggles every 110 edges while custom.
   function automatic logic exp_custom(input int kk);
      return ((kk - 1) / 110) % 2 == 1;
   endfunction

   // ch3 after switching to burst after edge 1445: partial second at PH 0.., then BS=0 again from edge 2080.
   function automatic logic exp_ch3_sw(input int kk);
      int j, o;
      j = kk - 1;
      if (j < 2080) return ((j >= 1446) && (j < 1460)) || ((j >= 1480) && (j < 1500));
      o = (j - 2080) % 640;
      return (o < 20) || ((o >= 40) && (o < 60));
   endfunction

   task automatic test_reset();
      RESET_N     = 1'b0;
      MODE_I      = '0;
      LAMP_TEST_I = 1'b0;
      repeat (3) step();
      checks++;
      if (LED_O !== 4'h0) begin errors++; $display("FAIL reset_led got %h expected 0", LED_O); end
      checks++;
      if (TICK_O !== 1'b0) begin errors++; $display("FAIL reset_tick got %b expected 0", TICK_O); end
      checks++;
      if (PHASE_O !== 4'h0) begin errors++; $display("FAIL reset_phase got %h expected 0", PHASE_O); end
      RESET_N = 1'b1;
   endtask

   task automatic test_tick_phase();
      logic       e_tick;
      logic [3:0] e_ph;
      for (int kk = 1; kk <= 170; kk++) begin
         step();
         e_tick = (kk >= 10) && (kk % 10 == 0);
         e_ph   = 4'((kk / 10) % 16);
         checks++;
         if (TICK_O !== e_tick) begin errors++; $display("FAIL tick k=%0d got %b expected %b", kk, TICK_O, e_tick); end
         checks++;
         if (PHASE_O !== e_ph) begin errors++; $display("FAIL phase k=%0d got %h expected %h", kk, PHASE_O, e_ph); end
         checks++;
         if (LED_O !== 4'h0) begin errors++; $display("FAIL off_led k=%0d got %h expected 0", kk, LED_O); end
      end
   endtask

   task automatic test_patterns();
      logic [3:0] e;
      RESET_N = 1'b0;
      MODE_I  = {3'd6, 3'd5, 3'd4, 3'd2};
      repeat (2) step();
      RESET_N = 1'b1;
      for (k = 1; k <= 1445; k++) begin
         step();
         e = (k == 1) ? 4'h0 : {exp_custom(k), exp_low3(k)};
         checks++;
         if (LED_O !== e) begin errors++; $display("FAIL pattern k=%0d got %h expected %h", k, LED_O, e); end
      end
   endtask

   task automatic test_mode_switch();
      logic [3:0] e;
      MODE_I[11:9] = 3'd5;
      for (k = 1446; k <= 2300; k++) begin
         step();
         e = {exp_ch3_sw(k), exp_low3(k)};
         checks++;
         if (LED_O !== e) begin errors++; $display("FAIL mode_switch k=%0d got %h expected %h", k, LED_O, e); end
      end
   endtask

   task automatic test_lamp_test();
      logic [3:0] e;
      LAMP_TEST_I = 1'b1;
      for (k = 2301; k <= 2350; k++) begin
         step();
         checks++;
         if (LED_O !== 4'hF) begin errors++; $display("FAIL lamp_on k=%0d got %h expected f", k, LED_O); end
      end
      LAMP_TEST_I = 1'b0;
      for (k = 2351; k <= 2700; k++) begin
         step();
         e = {exp_ch3_sw(k), exp_low3(k)};
         checks++;
         if (LED_O !== e) begin errors++; $display("FAIL lamp_release k=%0d got %h expected %h", k, LED_O, e); end
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] e;
      logic [2:0] lo;
      logic       e_tick;
      logic [3:0] e_ph;
      for (k = 2701; k <= 3205; k++) begin
         step();
         e = {exp_ch3_sw(k), exp_low3(k)};
         checks++;
         if (LED_O !== e) begin errors++; $display("FAIL pre_reset k=%0d got %h expected %h", k, LED_O, e); end
      end
      RESET_N = 1'b0;
      #1;
      checks++;
      if (LED_O !== 4'h0) begin errors++; $display("FAIL midreset_led got %h expected 0", LED_O); end
      checks++;
      if (TICK_O !== 1'b0) begin errors++; $display("FAIL midreset_tick got %b expected 0", TICK_O); end
      checks++;
      if (PHASE_O !== 4'h0) begin errors++; $display("FAIL midreset_phase got %h expected 0", PHASE_O); end
      step();
      RESET_N = 1'b1;
      for (int kk = 1; kk <= 40; kk++) begin
         step();
         lo     = exp_low3(kk);
         e      = (kk == 1) ? 4'h0 : {lo[2], lo};
         e_tick = (kk >= 10) && (kk % 10 == 0);
         e_ph   = 4'((kk / 10) % 16);
         checks++;
         if (LED_O !== e) begin errors++; $display("FAIL restart_led k=%0d got %h expected %h", kk, LED_O, e); end
         checks++;
         if (TICK_O !== e_tick) begin errors++; $display("FAIL restart_tick k=%0d got %b expected %b", kk, TICK_O, e_tick); end
         checks++;
         if (PHASE_O !== e_ph) begin errors++; $display("FAIL restart_phase k=%0d got %h expected %h", kk, PHASE_O, e_ph); end
      end
   endtask

   initial begin
      test_reset();
      test_tick_phase();
      test_patterns();
      test_mode_switch();
      test_lamp_test();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Multi-channel LED blink-pattern generator for the Status CPLD.
- Replaces fixed 1/2/4 Hz, 4 Hz-burst and 0.7 s wave outputs with one shared prescaler and a common phase counter.
- Each channel has a runtime-selectable pattern mode.
- All channels derived from the common phase blink in lock-step; outputs drive LED pins directly after the top-level polarity stage.

Parameters:
- CLK_FRQ, 25000000, SYSCLK frequency in Hz; must be a multiple of 16.
- NUM_CH, 4, number of LED channels (1..16).
- BURST_SEC, 4, burst-mode repeat period in seconds (2..15).
- CUST_TICKS, 11, custom-mode half-period in ticks (1..255; 11 gives 0.6875 s).

Ports:
- SYSCLK  input  1  system clock.
- RESET_N  input  1  reset.
- MODE_I  input  3*NUM_CH  per-channel mode; channel n uses bits [3n+2:3n].
- LAMP_TEST_I  input  1  forces all LED_O high while asserted.
- LED_O  output  NUM_CH  registered LED drive, 1 = lit.
- TICK_O  output  1  one-cycle pulse every 1/16 s.
- PHASE_O  output  4  current global phase.

Behaviour:
- Reset: RESET_N is asynchronous, active-low; clock is SYSCLK. While low, all counters are 0, mode_q is 0, and LED_O, TICK_O and PHASE_O are 0. Reset mid-operation clears everything immediately.
- Prescaler PRE counts 0..TICK_DIV-1, with TICK_DIV = CLK_FRQ/16; width is $clog2(TICK_DIV). It wraps to 0 after TICK_DIV-1.
- TICK_O is registered: high for exactly the one cycle after PRE == TICK_DIV-1. The first tick after reset release occurs at cycle TICK_DIV.
- PH is 4 bits. It increments on every tick, wraps 15->0, and PHASE_O = PH. One full PH cycle is 1 s.
- Per-channel registers:
  - mode_q (3 bits).
  - BS (burst seconds, 4 bits): increments on a tick with PH == 15; wraps at BURST_SEC-1.
  - CC (custom tick counter, 8 bits).
  - CT (custom toggle bit).
- Mode change: when MODE_I[n] != mode_q[n], mode_q loads the new value and BS, CC and CT clear to 0. LED_O[n] is 0 in the following cycle. The mode change has priority over a coincident tick, which is ignored for that channel's local counters.
- Modes (next LED_O[n], registered, 1-cycle latency from PH/state):
  - 0 OFF: 0.
  - 1 ON: 1.
  - 2 1HZ: PH < 8.
  - 3 2HZ: PH[2] == 0.
  - 4 4HZ: PH[1] == 0.
  - 5 BURST: (BS == 0) & (PH < 8) & (PH[1] == 0), giving two 4 Hz flashes in the first 0.5 s, then dark until BS wraps.
  - 6 CUSTOM: CT. On a tick, if CC == CUST_TICKS-1 then CC <= 0 and CT toggles; otherwise CC increments.
  - 7 reserved: 0.
- BS and CC run only in their own modes and hold at 0 otherwise.
- Lock-step: modes 2–5 share PH, so all rising edges coincide with PH transitioning to 0 (or to the relevant sub-phase).
- LAMP_TEST_I: LED_O is all ones one cycle after assertion. Internal counters keep running, so patterns resume in phase on release.
- No handshake; MODE_I is sampled every cycle.

Optional Feature:
- Macro LED_PAT_SYNC_EN.
- Defined: MODE_I and LAMP_TEST_I pass through a 2-flop synchronizer, reset to 0, before use. Mode-change and lamp-test latency become 3 cycles.
- Undefined: inputs are used directly, latency 1 cycle, and the inputs must be SYSCLK-synchronous.

Test Plan:
- All tests use CLK_FRQ=160 (TICK_DIV=10), NUM_CH=4, BURST_SEC=4, CUST_TICKS=11, macro undefined.
- Reset, MODE_I=0 -> LED_O=0; TICK_O first high at cycle 10 after release, then every 10 cycles; PHASE_O increments 0..15 and wraps.
- ch0 mode 2 from reset -> LED_O[0] high 80 cycles, low 80, period 160; ch1 mode 4 -> high 20, low 20; rising edges of ch0/ch1 coincide at PH=0.
- ch2 mode 5 -> exactly two 20-cycle pulses in the first 80 cycles of a 640-cycle window, low for the remaining 560; repeats.
- ch3 mode 6 -> LED_O[3] toggles every 110 cycles. Switch ch3 to mode 5 mid-count -> LED_O[3]=0 next cycle, BS restarts at 0.
- LAMP_TEST_I pulsed 50 cycles during mode 2 -> LED_O=4'hF within 1 cycle; after release, 1 Hz waveform continues with the original phase.
- Assert RESET_N low mid-burst for 1 cycle -> all outputs 0 immediately; after release the sequence restarts from the first tick at cycle 10.
